// File: rtl/hazard_fwd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl_pkg
//   Shared definitions for the pipeline hazard / forwarding controller:
//   forwarding-mux select codes, producer Tnew values and default widths.
//   Imported by hazard_fwd_ctrl and fwd_pick.
// ---------------------------------------------------------------------------
package hazard_fwd_ctrl_pkg;

   // Default widths: 32 architectural registers, Tuse/Tnew range 0..3.
   localparam int AW_DEF = 5;
   localparam int TW_DEF = 2;

   // Forwarding mux select codes. The numeric values follow the physical
   // input order of the operand muxes. 2'b11 is never produced.
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,  // register file / value already in the pipeline latch
      FWD_M  = 2'b01,  // result sitting in the M stage
      FWD_W  = 2'b10   // result sitting in the W stage
   } fwd_sel_e;

   // Cycles after entering E until the producer's result exists.
   localparam int TNEW_NONE = 0;  // jal-style: value known at decode
   localparam int TNEW_ALU  = 1;  // ALU result at end of E
   localparam int TNEW_LOAD = 2;  // load data at end of M

endpackage : hazard_fwd_ctrl_pkg

// File: rtl/hazard_fwd_ctrl_fwd_pick.sv
// ---------------------------------------------------------------------------
// fwd_pick
//   Pure combinational forwarding-source selector for one consumer operand.
//   Prefers the nearest stage holding a ready result: M if it writes the
//   source register and its value already exists, else W if it writes the
//   source register, else the register file. Register 0 never matches.
//
// Ports
//   i_src     source register address of the consumer operand
//   i_m_wa    destination address of the instruction in M (0 = none)
//   i_m_tnew  remaining cycles until the M-stage result exists
//   i_w_wa    destination address of the instruction in W (0 = none)
//   o_sel     forwarding mux select (FWD_RF / FWD_M / FWD_W)
// ---------------------------------------------------------------------------
module fwd_pick
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic [AW-1:0] i_src,
   input  logic [AW-1:0] i_m_wa,
   input  logic [TW-1:0] i_m_tnew,
   input  logic [AW-1:0] i_w_wa,
   output logic [1:0]    o_sel
);

   logic w_src_nz;
   logic w_m_hit;
   logic w_w_hit;

   // Register 0 is hard-wired; a write to it must never be forwarded.
   assign w_src_nz = (i_src != '0);
   assign w_m_hit  = w_src_nz && (i_src == i_m_wa);
   assign w_w_hit  = w_src_nz && (i_src == i_w_wa);

   // An M match whose value is not ready yet falls through to W. The stall
   // logic guarantees the consumer does not need the operand this cycle.
   // NOTE: o_sel gets a default before any branch so no latch is inferred.
   always_comb begin
      o_sel = FWD_RF;
      if (w_m_hit && (i_m_tnew == '0)) begin
         o_sel = FWD_M;
      end else if (w_w_hit) begin
         o_sel = FWD_W;
      end
   end

endmodule : fwd_pick

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard detection and operand-forwarding control for a 5-stage pipeline.
//   Tracks destination address and Tnew of the instructions in E, M and W,
//   and compares them with the D- and E-stage source registers to drive the
//   forwarding mux selects and the D-stage stall.
//
// Ports
//   clk        pipeline clock, rising edge
//   reset      asynchronous active-low reset; clears all tracked state
//   d_valid    D holds a real instruction (0 = bubble)
//   d_rs/d_rt  D-stage source register addresses
//   d_tuse_rs  cycles until the D instruction needs rs (0 = needed in D)
//   d_tuse_rt  same for rt
//   d_wa       D-stage destination address (0 = no write)
//   d_tnew     cycles after entering E until the D instruction's result exists
//   stall      freeze PC and IF/ID, insert a bubble into E
//   fwd_d_rs   D-stage rs mux select     fwd_d_rt  D-stage rt mux select
//   fwd_e_rs   E-stage rs mux select     fwd_e_rt  E-stage rt mux select
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int TW = TW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          d_valid,
   input  logic [AW-1:0] d_rs,
   input  logic [AW-1:0] d_rt,
   input  logic [TW-1:0] d_tuse_rs,
   input  logic [TW-1:0] d_tuse_rt,
   input  logic [AW-1:0] d_wa,
   input  logic [TW-1:0] d_tnew,
   output logic          stall,
   output logic [1:0]    fwd_d_rs,
   output logic [1:0]    fwd_d_rt,
   output logic [1:0]    fwd_e_rs,
   output logic [1:0]    fwd_e_rt
);

   // ------------------------------------------------------------------
   // Tracked pipeline state
   // ------------------------------------------------------------------
   logic [AW-1:0] r_e_rs;
   logic [AW-1:0] r_e_rt;
   logic [AW-1:0] r_e_wa;
   logic [TW-1:0] r_e_tnew;
   logic [AW-1:0] r_m_wa;
   logic [TW-1:0] r_m_tnew;
   logic [AW-1:0] r_w_wa;   // W Tnew is always 0, so only the address is kept

   // ------------------------------------------------------------------
   // Stall detection: a D operand stalls when a producer in E or M writes
   // it and will not have the value before the consumer needs it.
   // ------------------------------------------------------------------
   logic w_rs_nz;
   logic w_rt_nz;
   logic w_rs_e_stall;
   logic w_rs_m_stall;
   logic w_rt_e_stall;
   logic w_rt_m_stall;
   logic w_bubble;

   assign w_rs_nz = (d_rs != '0);
   assign w_rt_nz = (d_rt != '0);

   assign w_rs_e_stall = w_rs_nz && (d_rs == r_e_wa) && (d_tuse_rs < r_e_tnew);
   assign w_rs_m_stall = w_rs_nz && (d_rs == r_m_wa) && (d_tuse_rs < r_m_tnew);
   assign w_rt_e_stall = w_rt_nz && (d_rt == r_e_wa) && (d_tuse_rt < r_e_tnew);
   assign w_rt_m_stall = w_rt_nz && (d_rt == r_m_wa) && (d_tuse_rt < r_m_tnew);

   assign stall = d_valid &&
                  (w_rs_e_stall || w_rs_m_stall || w_rt_e_stall || w_rt_m_stall);

   // E receives a bubble whenever D is frozen or D holds no instruction.
   assign w_bubble = stall || !d_valid;

   // ------------------------------------------------------------------
   // Forwarding selects
   // ------------------------------------------------------------------
   logic [1:0] w_pick_d_rs;
   logic [1:0] w_pick_d_rt;

   fwd_pick #(.AW(AW), .TW(TW)) u_pick_d_rs (
      .i_src    (d_rs),
      .i_m_wa   (r_m_wa),
      .i_m_tnew (r_m_tnew),
      .i_w_wa   (r_w_wa),
      .o_sel    (w_pick_d_rs)
   );

   fwd_pick #(.AW(AW), .TW(TW)) u_pick_d_rt (
      .i_src    (d_rt),
      .i_m_wa   (r_m_wa),
      .i_m_tnew (r_m_tnew),
      .i_w_wa   (r_w_wa),
      .o_sel    (w_pick_d_rt)
   );

   // E-stage selects need no gating: a bubble in E has zero source
   // addresses, which can never match.
   fwd_pick #(.AW(AW), .TW(TW)) u_pick_e_rs (
      .i_src    (r_e_rs),
      .i_m_wa   (r_m_wa),
      .i_m_tnew (r_m_tnew),
      .i_w_wa   (r_w_wa),
      .o_sel    (fwd_e_rs)
   );

   fwd_pick #(.AW(AW), .TW(TW)) u_pick_e_rt (
      .i_src    (r_e_rt),
      .i_m_wa   (r_m_wa),
      .i_m_tnew (r_m_tnew),
      .i_w_wa   (r_w_wa),
      .o_sel    (fwd_e_rt)
   );

   // A bubble in D must not steer the D muxes. A stalled but valid D keeps
   // its select so a W-stage value is still captured while E is bubbled.
   assign fwd_d_rs = d_valid ? w_pick_d_rs : FWD_RF;
   assign fwd_d_rt = d_valid ? w_pick_d_rt : FWD_RF;

   // ------------------------------------------------------------------
   // Pipeline advance
   // ------------------------------------------------------------------
   // NOTE: state uses non-blocking assignments so every stage samples the
   // previous stage's value from before this edge, not the freshly updated one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_e_rs   <= '0;
         r_e_rt   <= '0;
         r_e_wa   <= '0;
         r_e_tnew <= '0;
         r_m_wa   <= '0;
         r_m_tnew <= '0;
         r_w_wa   <= '0;
      end else begin
         // Tnew counts down one per stage and saturates at zero.
         r_m_wa   <= r_e_wa;
         r_m_tnew <= (r_e_tnew == '0) ? '0 : r_e_tnew - TW'(1);
         r_w_wa   <= r_m_wa;

         if (w_bubble) begin
            r_e_rs   <= '0;
            r_e_rt   <= '0;
            r_e_wa   <= '0;
            r_e_tnew <= '0;
         end else begin
            r_e_rs   <= d_rs;
            r_e_rt   <= d_rt;
            r_e_wa   <= d_wa;
            r_e_tnew <= d_tnew;
         end
      end
   end

endmodule : hazard_fwd_ctrl

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Directed-vector bench for hazard_fwd_ctrl. All outputs are compared at
//   once as a 9-bit vector {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}
//   whose expected values are worked out by hand from the pipeline rules.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;
   import hazard_fwd_ctrl_pkg::*;

   localparam int AW = AW_DEF;
   localparam int TW = TW_DEF;

   logic          clk = 1'b0;
   logic          reset;
   logic          d_valid;
   logic [AW-1:0] d_rs;
   logic [AW-1:0] d_rt;
   logic [TW-1:0] d_tuse_rs;
   logic [TW-1:0] d_tuse_rt;
   logic [AW-1:0] d_wa;
   logic [TW-1:0] d_tnew;
   logic          stall;
   logic [1:0]    fwd_d_rs;
   logic [1:0]    fwd_d_rt;
   logic [1:0]    fwd_e_rs;
   logic [1:0]    fwd_e_rt;

   logic [8:0]    w_obs;
   logic [8:0]    exp_v;
   int            checks = 0;
   int            errors = 0;

   hazard_fwd_ctrl #(.AW(AW), .TW(TW)) dut (
      .clk       (clk),
      .reset     (reset),
      .d_valid   (d_valid),
      .d_rs      (d_rs),
      .d_rt      (d_rt),
      .d_tuse_rs (d_tuse_rs),
      .d_tuse_rt (d_tuse_rt),
      .d_wa      (d_wa),
      .d_tnew    (d_tnew),
      .stall     (stall),
      .fwd_d_rs  (fwd_d_rs),
      .fwd_d_rt  (fwd_d_rt),
      .fwd_e_rs  (fwd_e_rs),
      .fwd_e_rt  (fwd_e_rt)
   );

   always #5 clk = ~clk;

   assign w_obs = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt};

   // Present one instruction in D.
   task automatic drive(input logic v, input int rs, input int rt,
                        input int tu_rs, input int tu_rt,
                        input int wa, input int tnew);
      d_valid   = v;
      d_rs      = AW'(rs);
      d_rt      = AW'(rt);
      d_tuse_rs = TW'(tu_rs);
      d_tuse_rt = TW'(tu_rt);
      d_wa      = AW'(wa);
      d_tnew    = TW'(tnew);
   endtask

   task automatic drive_idle();
      drive(1'b0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advance one clock; inputs change and outputs are sampled well after the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b0;
      drive(1'b1, 5, 5, 0, 0, 5, TNEW_ALU);
      #1;
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL reset_hold: got %b expected %b", w_obs, exp_v); end
      step();
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL reset_hold_edge: got %b expected %b", w_obs, exp_v); end
      reset = 1'b1;
      #1;
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL reset_release: got %b expected %b", w_obs, exp_v); end
      // One edge after release E holds wa=5/tnew=1, so rs=5 with tuse 0 stalls.
      step();
      #1;
      exp_v = 9'b1_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL reset_first_cycle: got %b expected %b", w_obs, exp_v); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_alu_fwd();
      do_reset();
      drive(1'b1, 1, 2, 1, 1, 3, TNEW_ALU);              // add $3
      #1;
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL alu_prod: got %b expected %b", w_obs, exp_v); end
      step();
      drive(1'b1, 3, 0, 1, 1, 8, TNEW_ALU);              // consumer 1 reads $3
      #1;
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL alu_d: got %b expected %b", w_obs, exp_v); end
      step();
      drive(1'b1, 3, 0, 1, 1, 10, TNEW_ALU);             // consumer 2 reads $3
      #1;
      exp_v = 9'b0_01_00_01_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL alu_e_m: got %b expected %b", w_obs, exp_v); end
      step();
      drive(1'b0, 3, 0, 0, 0, 0, TNEW_NONE);             // bubble in D: D selects forced 00
      #1;
      exp_v = 9'b0_00_00_10_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL alu_e_w: got %b expected %b", w_obs, exp_v); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_load_use();
      do_reset();
      drive(1'b1, 1, 0, 1, 1, 4, TNEW_LOAD);             // lw $4
      step();
      drive(1'b1, 4, 9, 0, 0, 9, TNEW_ALU);              // needs $4 in D
      #1;
      exp_v = 9'b1_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL lu_stall1: got %b expected %b", w_obs, exp_v); end
      step();
      #1;
      exp_v = 9'b1_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL lu_stall2: got %b expected %b", w_obs, exp_v); end
      step();
      #1;
      exp_v = 9'b0_10_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL lu_release: got %b expected %b", w_obs, exp_v); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_stall_with_w();
      do_reset();
      drive(1'b1, 1, 1, 1, 1, 6, TNEW_ALU);              // add $6
      step();
      drive(1'b1, 1, 1, 1, 1, 4, TNEW_LOAD);             // lw $4
      step();
      drive_idle();
      step();
      // M = lw $4 (tnew 1), W = add $6: stall on rt, rs still forwarded from W.
      drive(1'b1, 6, 4, 0, 0, 0, TNEW_NONE);
      #1;
      exp_v = 9'b1_10_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL stall_w: got %b expected %b", w_obs, exp_v); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reg_zero();
      do_reset();
      drive(1'b1, 0, 0, 0, 0, 0, TNEW_LOAD);             // writes $0
      #1;
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL r0_prod: got %b expected %b", w_obs, exp_v); end
      drive(1'b1, 0, 0, 0, 0, 0, TNEW_ALU);              // reads $0 in D
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         exp_v = 9'b0_00_00_00_00; checks++;
         if (w_obs !== exp_v) begin errors++; $display("FAIL r0_cycle%0d: got %b expected %b", i, w_obs, exp_v); end
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_dual_match();
      // M (tnew 0) and W both write $7: M wins.
      do_reset();
      drive(1'b1, 1, 1, 1, 1, 7, TNEW_ALU);
      step();
      drive(1'b1, 1, 1, 1, 1, 7, TNEW_ALU);
      step();
      drive(1'b1, 0, 7, 1, 1, 0, TNEW_NONE);
      #1;
      exp_v = 9'b0_00_01_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL dual_d: got %b expected %b", w_obs, exp_v); end
      step();
      drive_idle();
      #1;
      exp_v = 9'b0_00_00_00_01; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL dual_m_ready: got %b expected %b", w_obs, exp_v); end
      // M writes $7 but is still at tnew 1: falls through to W.
      do_reset();
      drive(1'b1, 1, 1, 1, 1, 7, TNEW_ALU);
      step();
      drive(1'b1, 1, 1, 1, 1, 7, TNEW_LOAD);
      step();
      drive(1'b1, 0, 7, 2, 2, 0, TNEW_NONE);
      #1;
      exp_v = 9'b0_00_01_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL dual_d2: got %b expected %b", w_obs, exp_v); end
      step();
      drive_idle();
      #1;
      exp_v = 9'b0_00_00_00_10; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL dual_m_busy: got %b expected %b", w_obs, exp_v); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_tnew_zero();
      do_reset();
      drive(1'b1, 0, 0, 1, 1, 31, TNEW_NONE);            // jal writes $31
      step();
      drive(1'b1, 31, 0, 0, 0, 0, TNEW_NONE);
      #1;
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL tnew0_e: got %b expected %b", w_obs, exp_v); end
      step();
      // M tnew must saturate at 0, not wrap: no stall, M forwarded to D and E.
      #1;
      exp_v = 9'b0_01_00_01_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL tnew0_m: got %b expected %b", w_obs, exp_v); end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid_stall();
      do_reset();
      drive(1'b1, 1, 0, 1, 1, 4, TNEW_LOAD);
      step();
      drive(1'b1, 4, 0, 0, 0, 0, TNEW_ALU);
      #1;
      exp_v = 9'b1_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL mid_pre: got %b expected %b", w_obs, exp_v); end
      #1;
      reset = 1'b0;
      #1;
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL mid_async: got %b expected %b", w_obs, exp_v); end
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL mid_release: got %b expected %b", w_obs, exp_v); end
      step();
      #1;
      exp_v = 9'b0_00_00_00_00; checks++;
      if (w_obs !== exp_v) begin errors++; $display("FAIL mid_after: got %b expected %b", w_obs, exp_v); end
   endtask

   // ------------------------------------------------------------------
   initial begin
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_stall_with_w();
      test_reg_zero();
      test_dual_match();
      test_tnew_zero();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_hazard_fwd_ctrl
